// File: rtl/ps2_key_pkg.sv
// Shared PS2 scan-code constants and decoder state encoding.
package ps2_key_pkg;

  localparam logic [7:0] EXT_PREFIX    = 8'hE0;
  localparam logic [7:0] BRK_PREFIX    = 8'hF0;
  localparam logic [7:0] LEFT_DEFAULT  = 8'h6B;
  localparam logic [7:0] RIGHT_DEFAULT = 8'h74;
  localparam logic [7:0] FIRE_DEFAULT  = 8'h29;
  localparam logic [7:0] PAUSE_DEFAULT = 8'h4D;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } seq_state_t;

endpackage

// File: rtl/ps2_seq_decoder.sv
// PS2 byte-sequence decoder: turns E0/F0 prefixed byte streams into one-cycle
// make/break strobes, abandoning a stale prefix after PREFIX_TIMEOUT idle cycles.
//
// state      | meaning
// -----------+-----------------------------------------
// ST_IDLE    | no prefix pending
// ST_BRK     | F0 received, next byte is a break code
// ST_EXT     | E0 received, next byte is extended make or F0
// ST_EXT_BRK | E0 F0 received, next byte is extended break code
module ps2_seq_decoder
  import ps2_key_pkg::*;
#(
  parameter logic [15:0] PREFIX_TIMEOUT = 16'd50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic       ev_valid,
  output logic       ev_make,
  output logic [7:0] ev_code,
  output logic       ev_ext
);

  seq_state_t  state, state_next;
  logic [15:0] timer;
  logic        timeout;

  // Timer reloads on every byte, so it only expires after a full idle gap.
  assign timeout = (state != ST_IDLE) && !key_valid && (timer == 16'd0);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= ST_IDLE;
      timer <= 16'd0;
    end else begin
      state <= state_next;
      if (key_valid)
        timer <= PREFIX_TIMEOUT;
      else if (timer != 16'd0)
        timer <= timer - 16'd1;
    end
  end

  always_comb begin
    state_next = state;
    if (key_valid) begin
      case (state)
        ST_IDLE: begin
          if (key_code == EXT_PREFIX)      state_next = ST_EXT;
          else if (key_code == BRK_PREFIX) state_next = ST_BRK;
        end
        ST_EXT:  state_next = (key_code == BRK_PREFIX) ? ST_EXT_BRK : ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_next = ST_IDLE;
    end
  end

  always_comb begin
    ev_valid = 1'b0;
    ev_make  = 1'b0;
    ev_ext   = 1'b0;
    ev_code  = key_code;
    if (key_valid) begin
      case (state)
        ST_IDLE: begin
          if ((key_code != EXT_PREFIX) && (key_code != BRK_PREFIX)) begin
            ev_valid = 1'b1;
            ev_make  = 1'b1;
          end
        end
        ST_EXT: begin
          if (key_code != BRK_PREFIX) begin
            ev_valid = 1'b1;
            ev_make  = 1'b1;
            ev_ext   = 1'b1;
          end
        end
        ST_BRK:     ev_valid = 1'b1;
        ST_EXT_BRK: begin
          ev_valid = 1'b1;
          ev_ext   = 1'b1;
        end
        default: ev_valid = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/key_command_ctrl.sv
// Keyboard command controller: held-key tracking, left/right arbitration,
// fire cooldown and pause toggle driven by decoded PS2 make/break events.
module key_command_ctrl
  import ps2_key_pkg::*;
#(
  parameter logic [7:0]  LEFT_CODE      = LEFT_DEFAULT,
  parameter logic [7:0]  RIGHT_CODE     = RIGHT_DEFAULT,
  parameter logic [7:0]  FIRE_CODE      = FIRE_DEFAULT,
  parameter logic [7:0]  PAUSE_CODE     = PAUSE_DEFAULT,
  parameter logic [7:0]  FIRE_COOLDOWN  = 8'd8,
  parameter logic [15:0] PREFIX_TIMEOUT = 16'd50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       frame_tick,
  output logic       move_left,
  output logic       move_right,
  output logic       fire,
  output logic       pause
);

  logic       ev_valid, ev_make, ev_ext;
  logic [7:0] ev_code;

  ps2_seq_decoder #(
    .PREFIX_TIMEOUT(PREFIX_TIMEOUT)
  ) u_dec (
    .clock    (clock),
    .resetn   (resetn),
    .key_valid(key_valid),
    .key_code (key_code),
    .ev_valid (ev_valid),
    .ev_make  (ev_make),
    .ev_code  (ev_code),
    .ev_ext   (ev_ext)
  );

  logic       left_held, right_held, fire_held, pause_held, dir_right;
  logic [7:0] cooldown;
  logic       left_held_n, right_held_n, fire_held_n, pause_held_n, dir_right_n;
  logic [7:0] cooldown_n;
  logic       move_left_n, move_right_n, fire_n, pause_n;
  logic       hit_left, hit_right, hit_fire, hit_pause;

  assign hit_left  = ev_valid &&  ev_ext && (ev_code == LEFT_CODE);
  assign hit_right = ev_valid &&  ev_ext && (ev_code == RIGHT_CODE);
  assign hit_fire  = ev_valid && !ev_ext && (ev_code == FIRE_CODE);
  assign hit_pause = ev_valid && !ev_ext && (ev_code == PAUSE_CODE);

  always_comb begin
    left_held_n  = hit_left  ? ev_make : left_held;
    right_held_n = hit_right ? ev_make : right_held;
    fire_held_n  = hit_fire  ? ev_make : fire_held;
    pause_held_n = hit_pause ? ev_make : pause_held;

    dir_right_n = dir_right;
    if (hit_left && ev_make)       dir_right_n = 1'b0;
    else if (hit_right && ev_make) dir_right_n = 1'b1;

    // Fire and cooldown gating use the pause value from before this cycle.
    fire_n  = hit_fire && ev_make && !fire_held && (cooldown == 8'd0) && !pause;
    pause_n = pause ^ (hit_pause && ev_make && !pause_held);

    cooldown_n = cooldown;
    if (fire_n)
      cooldown_n = FIRE_COOLDOWN;
    else if (frame_tick && !pause && (cooldown != 8'd0))
      cooldown_n = cooldown - 8'd1;

    // Active direction falls back to the other key when it is not held.
    move_left_n  = !pause_n && left_held_n  && (!dir_right_n || !right_held_n);
    move_right_n = !pause_n && right_held_n && ( dir_right_n || !left_held_n);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      left_held  <= 1'b0;
      right_held <= 1'b0;
      fire_held  <= 1'b0;
      pause_held <= 1'b0;
      dir_right  <= 1'b0;
      cooldown   <= 8'd0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
      fire       <= 1'b0;
      pause      <= 1'b0;
    end else begin
      left_held  <= left_held_n;
      right_held <= right_held_n;
      fire_held  <= fire_held_n;
      pause_held <= pause_held_n;
      dir_right  <= dir_right_n;
      cooldown   <= cooldown_n;
      move_left  <= move_left_n;
      move_right <= move_right_n;
      fire       <= fire_n;
      pause      <= pause_n;
    end
  end

endmodule

// File: tb/tb_key_command_ctrl.sv
// Bench for key_command_ctrl: directed scenarios plus random byte streams,
// checked cycle by cycle against a behavioural model of the key rules.
module tb_key_command_ctrl;

  localparam int T    = 100;
  localparam int COOL = 8;
  localparam logic [7:0] E0 = 8'hE0, F0 = 8'hF0;
  localparam logic [7:0] LK = 8'h6B, RK = 8'h74, FK = 8'h29, PK = 8'h4D;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       frame_tick = 1'b0;
  logic       move_left, move_right, fire, pause;

  int checks = 0;
  int errors = 0;
  int fire_cnt = 0;

  key_command_ctrl #(
    .FIRE_COOLDOWN (8'(COOL)),
    .PREFIX_TIMEOUT(16'(T))
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .key_valid (key_valid),
    .key_code  (key_code),
    .frame_tick(frame_tick),
    .move_left (move_left),
    .move_right(move_right),
    .fire      (fire),
    .pause     (pause)
  );

  always #5 clock = ~clock;

  // Model: pending prefixes, idle gap, stack of held directions (last = active).
  bit m_e0, m_f0, m_fh, m_ph, m_pause, m_fire;
  int m_gap, m_cd;
  int dq[$];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void dir_remove(input int d);
    for (int i = dq.size() - 1; i >= 0; i--)
      if (dq[i] == d) dq.delete(i);
  endfunction

  task automatic model_update(input bit kv, input logic [7:0] code, input bit ft, input bit rst);
    bit ev, mk, ext, fired, tog;
    if (!rst) begin
      m_e0 = 0; m_f0 = 0; m_gap = 0; dq.delete();
      m_fh = 0; m_ph = 0; m_cd = 0; m_pause = 0; m_fire = 0;
      return;
    end
    ev = 0; mk = 0; ext = 0;
    if (kv) begin
      m_gap = 0;
      if (m_f0) begin
        ev = 1; ext = m_e0; m_e0 = 0; m_f0 = 0;
      end else if (m_e0) begin
        if (code == F0) m_f0 = 1;
        else begin ev = 1; mk = 1; ext = 1; m_e0 = 0; end
      end else if (code == E0) m_e0 = 1;
      else if (code == F0) m_f0 = 1;
      else begin ev = 1; mk = 1; end
    end else if (m_e0 || m_f0) begin
      m_gap++;
      if (m_gap > T) begin m_e0 = 0; m_f0 = 0; end
    end
    fired = 0; tog = 0;
    if (ev) begin
      if (ext && code == LK) begin dir_remove(0); if (mk) dq.push_back(0); end
      if (ext && code == RK) begin dir_remove(1); if (mk) dq.push_back(1); end
      if (!ext && code == FK) begin
        if (mk && !m_fh && m_cd == 0 && !m_pause) fired = 1;
        m_fh = mk;
      end
      if (!ext && code == PK) begin
        if (mk && !m_ph) tog = 1;
        m_ph = mk;
      end
    end
    if (ft && !m_pause && m_cd > 0) m_cd--;
    if (fired) m_cd = COOL;
    if (tog) m_pause = !m_pause;
    m_fire = fired;
  endtask

  task automatic step(input bit kv, input logic [7:0] code, input bit ft, input bit rst);
    int exp_l, exp_r;
    key_valid = kv; key_code = code; frame_tick = ft; resetn = rst;
    @(posedge clock);
    model_update(kv, code, ft, rst);
    #1;
    exp_l = 0; exp_r = 0;
    if (!m_pause && dq.size() > 0) begin
      if (dq[dq.size() - 1] == 0) exp_l = 1;
      else exp_r = 1;
    end
    check("move_left", move_left, exp_l);
    check("move_right", move_right, exp_r);
    check("fire", fire, m_fire);
    check("pause", pause, m_pause);
    check("excl", move_left & move_right, 0);
    if (fire === 1'b1) fire_cnt++;
  endtask

  task automatic send(input logic [7:0] b);
    step(1, b, 0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 1);
  endtask

  task automatic tick();
    step(0, 8'h00, 1, 1);
  endtask

  initial begin
    logic [7:0] pool [7];
    logic [7:0] b;
    pool[0] = E0; pool[1] = F0; pool[2] = LK; pool[3] = RK;
    pool[4] = FK; pool[5] = PK; pool[6] = 8'h1C;

    step(1, LK, 1, 0);
    step(0, 8'h00, 0, 0);
    check("reset_all", {move_left, move_right, fire, pause}, 0);

    // Left make then extended break
    send(E0); send(LK);
    check("left_make", move_left, 1);
    send(E0); send(F0); send(LK);
    check("left_break", move_left, 0);

    // Last make wins, release falls back
    send(E0); send(LK); send(E0); send(RK);
    check("right_wins_r", move_right, 1);
    check("right_wins_l", move_left, 0);
    send(E0); send(F0); send(RK);
    check("fallback_left", move_left, 1);
    send(E0); send(F0); send(LK);
    check("none_held", {move_left, move_right}, 0);

    // Typematic fire, then cooldown
    fire_cnt = 0;
    send(FK); send(FK); send(FK);
    check("fire_once", fire_cnt, 1);
    send(F0); send(FK);
    for (int i = 0; i < COOL - 1; i++) tick();
    fire_cnt = 0;
    send(FK);
    check("fire_cooling", fire_cnt, 0);
    send(F0); send(FK);
    tick();
    send(FK);
    check("fire_ready", fire, 1);
    send(F0); send(FK);

    // Pause while left held
    send(E0); send(LK);
    send(PK); send(F0); send(PK);
    check("paused", pause, 1);
    check("paused_move", move_left, 0);
    send(PK);
    check("unpaused", pause, 0);
    check("resume_left", move_left, 1);
    send(F0); send(PK); send(E0); send(F0); send(LK);

    // Prefix timeout boundary
    send(E0); idle(T); send(LK);
    check("no_timeout", move_left, 1);
    send(E0); send(F0); send(LK);
    send(E0); idle(T + 1); send(LK);
    check("timeout", move_left, 0);

    // Reset mid-sequence
    send(E0);
    step(1, LK, 0, 0);
    check("midseq_reset", {move_left, move_right, fire, pause}, 0);
    send(LK);
    check("after_reset", move_left, 0);

    // Random byte streams
    for (int n = 0; n < 4000; n++) begin
      b = pool[$urandom_range(0, 6)];
      if ($urandom_range(0, 99) < 3) b = 8'($urandom);
      if ($urandom_range(0, 699) == 0) step(1, b, 0, 0);
      else step(1, b, $urandom_range(0, 3) == 0, 1);
      if ($urandom_range(0, 199) == 0) begin
        for (int g = 0; g < T + $urandom_range(0, 3) - 1; g++)
          step(0, 8'h00, $urandom_range(0, 3) == 0, 1);
      end else begin
        for (int g = 0; g < $urandom_range(0, 3); g++)
          step(0, 8'h00, $urandom_range(0, 2) == 0, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_command_ctrl.md
KEY_COMMAND_CTRL -- requirements
Module: key_command_ctrl

Interface
REQ-001 SHALL have parameter LEFT_CODE, 8'h6B, extended scan code for left arrow.
REQ-002 SHALL have parameter RIGHT_CODE, 8'h74, extended scan code for right arrow.
REQ-003 SHALL have parameter FIRE_CODE, 8'h29, non-extended scan code for space.
REQ-004 SHALL have parameter PAUSE_CODE, 8'h4D, non-extended scan code for P.
REQ-005 SHALL have parameter FIRE_COOLDOWN, 8, number of frame_tick pulses between shots (1..255).
REQ-006 SHALL have parameter PREFIX_TIMEOUT, 16'd50000, number of clock cycles allowed after a prefix byte.
REQ-007 SHALL have port clock, input, 1, single system clock; all logic on its rising edge.
REQ-008 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-009 SHALL have port key_valid, input, 1, one-cycle strobe marking a new PS2 byte.
REQ-010 SHALL have port key_code, input, 8, PS2 byte; sampled only when key_valid=1.
REQ-011 SHALL have port frame_tick, input, 1, one-cycle strobe once per VGA frame.
REQ-012 SHALL have port move_left, output, 1, level; left movement active.
REQ-013 SHALL have port move_right, output, 1, level; right movement active.
REQ-014 SHALL have port fire, output, 1, one-cycle pulse per accepted shot.
REQ-015 SHALL have port pause, output, 1, level; game paused.

Function
REQ-016 SHALL decode bytes with FSM states IDLE, BRK (after 8'hF0), EXT (after 8'hE0) and EXT_BRK (after E0 F0).
REQ-017 SHALL use these transitions: IDLE: E0->EXT, F0->BRK, other->make(code,ext=0)/IDLE; EXT: F0->EXT_BRK, other->make(code,ext=1)/IDLE; BRK: any->break(code,ext=0)/IDLE; EXT_BRK: any->break(code,ext=1)/IDLE.
REQ-018 SHALL return any non-IDLE state to IDLE with no effect once PREFIX_TIMEOUT cycles pass without key_valid; the counter SHALL clear on every key_valid.
REQ-019 SHALL track held flags left_held, right_held, fire_held and pause_held, set on make and cleared on break; codes or extension mismatches SHALL have no effect.
REQ-020 SHALL resolve left/right with last-make-wins: a make of one direction SHALL make it the active direction.
REQ-021 SHALL, when the active direction is released while the other is still held, switch to the other direction; with neither held, both outputs SHALL be 0.
REQ-022 SHALL never assert move_left and move_right together.
REQ-023 SHALL pulse fire for exactly one cycle on a FIRE_CODE make only if fire_held=0 beforehand (typematic repeats ignored), cooldown=0, and pause=0.
REQ-024 SHALL load cooldown with FIRE_COOLDOWN on a fire pulse.
REQ-025 SHALL decrement cooldown, when nonzero, on frame_tick while pause=0, saturating at 0.
REQ-026 SHALL resolve a same-cycle frame_tick and fire make using the pre-cycle cooldown value; if a fire occurs, the load SHALL win over the decrement.
REQ-027 SHALL toggle pause on a PAUSE_CODE make only if pause_held=0 beforehand.
REQ-028 SHALL, while pause=1, force move_left and move_right to 0 and suppress fire, while still updating the held flags, so that movement resumes per held keys after unpause.
REQ-029 SHALL register all outputs and reflect the effect of a key_valid byte on the cycle after it is sampled (latency 1).
REQ-030 SHALL ignore key_valid while resetn=0.

Reset
REQ-031 SHALL, when resetn=0 at a clock edge, set the FSM to IDLE, clear all held flags, set cooldown=0, clear the timeout counter, and drive move_left=0, move_right=0, fire=0 and pause=0.
REQ-032 SHALL discard a partially received sequence (e.g. E0 received, code pending) on reset mid-sequence, and SHALL interpret the next byte from IDLE.

Structure
REQ-033 SHALL place scan-code constants (E0, F0, default key codes) and the FSM state enum in shared package ps2_key_pkg.
REQ-034 SHALL implement the byte decoder FSM plus timeout as sub-module ps2_seq_decoder, outputting a one-cycle make/break strobe with code and ext.
REQ-035 SHALL implement the held flags, arbitration, cooldown and pause logic in key_command_ctrl.

Verification
REQ-036 SHALL verify: bytes E0 6B -> move_left=1 one cycle after the 6B byte; then E0 F0 6B -> move_left=0.
REQ-037 SHALL verify: E0 6B, then E0 74 -> move_right=1 and move_left=0; then E0 F0 74 -> move_left=1.
REQ-038 SHALL verify: 29, 29, 29 with no break -> exactly one fire pulse; F0 29, then 29 before 8 frame_ticks -> no pulse; 29 after 8 ticks -> pulse.
REQ-039 SHALL verify: 4D, F0 4D -> pause=1 and movement suppressed with left held; 4D again -> pause=0 and move_left=1 restored.
REQ-040 SHALL verify: E0, then a PREFIX_TIMEOUT+1 cycle gap, then 6B -> treated as a non-extended make, so move_left stays 0.
REQ-041 SHALL verify: resetn=0 asserted between E0 and 6B -> all outputs 0; the following 6B -> no movement.
